// File: rtl/bitfusion_mac_array.sv
// rtl/bitfusion_mac_array.sv - multi-lane bit-width-configurable dot-product accumulator
module bitfusion_mac_array #(
    parameter int LANES = 4,
    parameter int ACC_W = 32,
    parameter int LEN_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [1:0]         cfg_in_width,
    input  logic [1:0]         cfg_weight_width,
    input  logic               cfg_s_in,
    input  logic               cfg_s_weight,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [8*LANES-1:0] in_data,
    input  logic [8*LANES-1:0] weight_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [ACC_W-1:0]   psum,
    output logic               ovf,
    output logic               busy
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ACCUM = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;
    localparam logic [1:0] S_OUT   = 2'd3;

    logic [1:0]       state;
    logic [1:0]       next_state;
    logic [LEN_W-1:0] remaining;
    logic [1:0]       iw_c;
    logic [1:0]       ww_c;
    logic             s_in_q;
    logic             s_w_q;
    logic             s1_valid;
    logic [ACC_W-1:0] s1_sum;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] acc_next;
    logic [ACC_W-1:0] beat_sum;
    logic             accept;
    logic             add_ovf;

    // Width codes are stored normalised: 11 collapses onto 10 (8-bit).
    function automatic logic [1:0] norm_width(input logic [1:0] code);
        return (code == 2'b11) ? 2'b10 : code;
    endfunction

    function automatic logic signed [8:0] elem(input logic [7:0] word, input logic [1:0] wc,
                                               input logic sgn, input logic [1:0] k);
        logic [1:0] e2;
        logic [3:0] e4;
        logic signed [8:0] r;
        e2 = word[{k, 1'b0} +: 2];
        e4 = word[{k[0], 2'b00} +: 4];
        case (wc)
            2'b00:   r = {{7{sgn & e2[1]}}, e2};
            2'b01:   r = {{5{sgn & e4[3]}}, e4};
            default: r = {sgn & word[7], word};
        endcase
        return r;
    endfunction

    function automatic logic [ACC_W-1:0] calc_sum(input logic [8*LANES-1:0] d,
                                                  input logic [8*LANES-1:0] w,
                                                  input logic [1:0] iwc, input logic [1:0] wwc,
                                                  input logic si, input logic sw);
        logic [1:0] mx;
        logic [2:0] kcnt;
        logic signed [8:0] a;
        logic signed [8:0] b;
        logic signed [17:0] p;
        logic [ACC_W-1:0] s;
        mx = (iwc > wwc) ? iwc : wwc;
        case (mx)
            2'b00:   kcnt = 3'd4;
            2'b01:   kcnt = 3'd2;
            default: kcnt = 3'd1;
        endcase
        s = '0;
        for (int j = 0; j < LANES; j++) begin
            for (int k = 0; k < 4; k++) begin
                if (3'(k) < kcnt) begin
                    a = elem(d[8*j +: 8], iwc, si, 2'(k));
                    b = elem(w[8*j +: 8], wwc, sw, 2'(k));
                    p = a * b;
                    s = s + {{(ACC_W-18){p[17]}}, p};
                end
            end
        end
        return s;
    endfunction

    assign accept   = in_valid && in_ready;
    assign beat_sum = calc_sum(in_data, weight_data, iw_c, ww_c, s_in_q, s_w_q);
    assign acc_next = acc + s1_sum;
    assign add_ovf  = (acc[ACC_W-1] == s1_sum[ACC_W-1]) && (acc_next[ACC_W-1] != acc[ACC_W-1]);
    assign psum     = acc;

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:  if (start) next_state = (cfg_len == '0) ? S_FLUSH : S_ACCUM;
            S_ACCUM: if (accept && remaining == LEN_W'(1)) next_state = S_FLUSH;
            S_FLUSH: if (!s1_valid) next_state = S_OUT;
            default: if (out_ready) next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            remaining <= '0;
            iw_c      <= 2'b10;
            ww_c      <= 2'b10;
            s_in_q    <= 1'b0;
            s_w_q     <= 1'b0;
            s1_valid  <= 1'b0;
            s1_sum    <= '0;
            acc       <= '0;
            ovf       <= 1'b0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= next_state;
            in_ready  <= (next_state == S_ACCUM);
            out_valid <= (next_state == S_OUT);
            busy      <= (next_state != S_IDLE);
            s1_valid  <= accept;
            if (accept) begin
                s1_sum    <= beat_sum;
                remaining <= remaining - LEN_W'(1);
            end
            if (state == S_IDLE && start) begin
                iw_c      <= norm_width(cfg_in_width);
                ww_c      <= norm_width(cfg_weight_width);
                s_in_q    <= cfg_s_in;
                s_w_q     <= cfg_s_weight;
                remaining <= cfg_len;
                acc       <= '0;
                ovf       <= 1'b0;
            end else if (s1_valid) begin
                acc <= acc_next;
                ovf <= ovf | add_ovf;
            end
        end
    end

endmodule

// File: tb/tb_bitfusion_mac_array.sv
// tb/tb_bitfusion_mac_array.sv - directed bench for bitfusion_mac_array
module tb_bitfusion_mac_array;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [1:0]  cfg_in_width;
    logic [1:0]  cfg_weight_width;
    logic        cfg_s_in;
    logic        cfg_s_weight;
    logic [7:0]  cfg_len;
    logic        in_valid;
    logic        in_ready;
    logic        in_ready20;
    logic [31:0] in_data;
    logic [31:0] weight_data;
    logic        out_valid;
    logic        out_valid20;
    logic        out_ready;
    logic [31:0] psum;
    logic [19:0] psum20;
    logic        ovf;
    logic        ovf20;
    logic        busy;
    logic        busy20;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int ts;
    int tl;
    int tv;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    bitfusion_mac_array #(.LANES(4), .ACC_W(32), .LEN_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .cfg_in_width(cfg_in_width), .cfg_weight_width(cfg_weight_width),
        .cfg_s_in(cfg_s_in), .cfg_s_weight(cfg_s_weight), .cfg_len(cfg_len),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .weight_data(weight_data),
        .out_valid(out_valid), .out_ready(out_ready), .psum(psum), .ovf(ovf), .busy(busy)
    );

    bitfusion_mac_array #(.LANES(4), .ACC_W(20), .LEN_W(8)) dut20 (
        .clk(clk), .rst_n(rst_n), .start(start),
        .cfg_in_width(cfg_in_width), .cfg_weight_width(cfg_weight_width),
        .cfg_s_in(cfg_s_in), .cfg_s_weight(cfg_s_weight), .cfg_len(cfg_len),
        .in_valid(in_valid), .in_ready(in_ready20), .in_data(in_data), .weight_data(weight_data),
        .out_valid(out_valid20), .out_ready(out_ready), .psum(psum20), .ovf(ovf20), .busy(busy20)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [1:0] iw, input logic [1:0] ww, input logic si,
                            input logic sw, input logic [7:0] len, output int t);
        cfg_in_width     = iw;
        cfg_weight_width = ww;
        cfg_s_in         = si;
        cfg_s_weight     = sw;
        cfg_len          = len;
        start            = 1'b1;
        t                = cyc;
        tick();
        start            = 1'b0;
    endtask

    task automatic send_beats(input int n, input logic [31:0] d, input logic [31:0] w,
                              input bit gaps, output int t);
        int g;
        in_data     = d;
        weight_data = w;
        t           = cyc;
        for (int i = 0; i < n; i++) begin
            if (gaps) begin
                in_valid = 1'b0;
                tick();
                tick();
            end
            in_valid = 1'b1;
            g = 0;
            while (!in_ready && g < 20) begin
                tick();
                g++;
            end
            t = cyc;
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int t);
        int g;
        g = 0;
        while (!out_valid && g < 50) begin
            tick();
            g++;
        end
        t = cyc;
        check("out_valid_seen", {31'd0, out_valid}, 32'd1);
    endtask

    task automatic finish_out();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("idle_busy", {31'd0, busy}, 32'd0);
        check("idle_out_valid", {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        cfg_in_width = 2'b10; cfg_weight_width = 2'b10; cfg_s_in = 1'b0; cfg_s_weight = 1'b0;
        cfg_len = 8'd0; in_data = '0; weight_data = '0;
        tick();
        tick();
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_psum", psum, 32'd0);
        check("rst_ovf", {31'd0, ovf}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        rst_n = 1'b1;
        tick();

        // reset in the middle of a 5-beat job
        do_start(2'b10, 2'b10, 1'b0, 1'b0, 8'd5, ts);
        check("start_busy", {31'd0, busy}, 32'd1);
        send_beats(3, {4{8'h05}}, {4{8'h01}}, 1'b0, tl);
        rst_n = 1'b0;
        #1;
        check("midrst_in_ready", {31'd0, in_ready}, 32'd0);
        check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_psum", psum, 32'd0);
        check("midrst_ovf", {31'd0, ovf}, 32'd0);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        do_start(2'b10, 2'b10, 1'b0, 1'b0, 8'd1, ts);
        send_beats(1, 32'h0000_0001, 32'h0000_0001, 1'b0, tl);
        wait_out(tv);
        check("postrst_psum", psum, 32'd1);
        finish_out();

        // 4b signed: per lane 7*3 + (-1)*2 = 19, per beat 76, two beats 152
        do_start(2'b01, 2'b01, 1'b1, 1'b1, 8'd2, ts);
        send_beats(2, {4{8'hF7}}, {4{8'h23}}, 1'b0, tl);
        wait_out(tv);
        check("s4_latency", tv - tl, 32'd3);
        check("s4_psum", psum, 32'd152);
        check("s4_psum20", {12'd0, psum20}, 32'd152);
        check("s4_ovf", {31'd0, ovf}, 32'd0);
        finish_out();

        // 2b unsigned input x 8b signed weight: 3 * -128 per lane, 4 lanes
        do_start(2'b00, 2'b10, 1'b0, 1'b1, 8'd1, ts);
        send_beats(1, {4{8'hFF}}, {4{8'h80}}, 1'b0, tl);
        wait_out(tv);
        check("mix_psum", psum, 32'hFFFF_FA00);
        check("mix_psum20", {12'd0, psum20}, 32'h000F_FA00);
        finish_out();

        // zero-length job, then a start pulse during OUT
        do_start(2'b10, 2'b10, 1'b0, 1'b0, 8'd0, ts);
        wait_out(tv);
        check("len0_latency", tv - ts, 32'd2);
        check("len0_psum", psum, 32'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("len0_hold_valid", {31'd0, out_valid}, 32'd1);
        finish_out();
        tick();
        check("len0_start_ignored", {31'd0, busy}, 32'd0);

        // backpressure on the output, then same job with input gaps
        do_start(2'b10, 2'b10, 1'b0, 1'b0, 8'd3, ts);
        send_beats(3, {4{8'h02}}, {4{8'h03}}, 1'b0, tl);
        wait_out(tv);
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            check("bp_psum", psum, 32'd72);
            check("bp_busy", {31'd0, busy}, 32'd1);
            check("bp_in_ready", {31'd0, in_ready}, 32'd0);
            tick();
        end
        in_valid = 1'b0;
        check("bp_valid_held", {31'd0, out_valid}, 32'd1);
        finish_out();
        do_start(2'b10, 2'b10, 1'b0, 1'b0, 8'd3, ts);
        send_beats(3, {4{8'h02}}, {4{8'h03}}, 1'b1, tl);
        wait_out(tv);
        check("gap_psum", psum, 32'd72);
        check("gap_latency", tv - tl, 32'd3);
        finish_out();

        // (-128)*(-128)*4 per beat, 8 beats = 0x80000: overflows only a 20-bit accumulator
        do_start(2'b10, 2'b10, 1'b1, 1'b1, 8'd8, ts);
        send_beats(8, {4{8'h80}}, {4{8'h80}}, 1'b0, tl);
        wait_out(tv);
        check("ovf_psum32", psum, 32'h0008_0000);
        check("ovf_flag32", {31'd0, ovf}, 32'd0);
        check("ovf_psum20", {12'd0, psum20}, 32'h0008_0000);
        check("ovf_flag20", {31'd0, ovf20}, 32'd1);
        check("ovf_valid20", {31'd0, out_valid20}, 32'd1);
        finish_out();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
